// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the mux8 round-robin arbiter.
//   N_REQ          : number of requesters (fixed at 8, the mux fan-in)
//   SEL_W          : width of the mux select / requester index
//   state_t        : arbiter state encoding (IDLE, BUSY)
//   onehot_to_idx  : converts an 8-bit one-hot grant to its 3-bit index
// ---------------------------------------------------------------------------
package arb_pkg;

   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   // OR-reduction of indices; a zero vector maps to index 0.
   function automatic logic [SEL_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
      logic [SEL_W-1:0] r;
      r = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (oh[i]) r = r | SEL_W'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// ---------------------------------------------------------------------------
// rr_pick8
// Combinational round-robin picker: the first set bit of (req & mask),
// searching from index ptr upward and wrapping modulo 8.
// Ports:
//   req    [7:0] in  : request vector
//   ptr    [2:0] in  : search start index
//   mask   [7:0] in  : enables per requester (0 excludes the bit)
//   found        out : at least one candidate exists
//   idx    [2:0] out : winning index (0 when nothing is found)
//   onehot [7:0] out : one-hot of the winner (0 when nothing is found)
// ---------------------------------------------------------------------------
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   input  logic [N_REQ-1:0] mask,
   output logic             found,
   output logic [SEL_W-1:0] idx,
   output logic [N_REQ-1:0] onehot
);

   logic [N_REQ-1:0] cand;
   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   assign cand = req & mask;

   // Rotate so that bit 0 of rot is requester ptr; the 3-bit index sum wraps.
   always_comb begin
      rot = '0;
      for (int i = 0; i < N_REQ; i++) begin
         rot[i] = cand[SEL_W'(i) + ptr];
      end
   end

   // Lowest set bit of the rotated vector; scanning downward lets the
   // last hit (the lowest index) win.
   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            found = 1'b1;
            off   = SEL_W'(i);
         end
      end
   end

   // Rotate back to an absolute index.
   assign idx    = found ? (off + ptr) : '0;
   assign onehot = found ? (N_REQ'(1) << idx) : '0;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux8_rr_arbiter
// Round-robin arbiter that shares one 8:1 datapath mux among 8 requesters.
// A grant is held until the resource pulses done or the requester withdraws;
// on release the arbiter re-arbitrates in the same cycle, so back-to-back
// grants have no idle bubble. The mux selects are driven directly.
// Ports:
//   clk        in  : rising-edge clock
//   rst_n      in  : asynchronous active-low reset
//   req[7:0]   in  : request per requester (bit i <-> mux input Di)
//   done       in  : one-cycle pulse, current transfer finished
//   gnt[7:0]   out : registered one-hot grant
//   gnt_valid  out : high while a grant is held
//   sel_s0     out : mux select MSB (sel[2])
//   sel_s1     out : mux select middle bit (sel[1])
//   sel_s2     out : mux select LSB (sel[0])
//   timeout    out : one-cycle pulse when a grant is forcibly revoked
// Build option:
//   ARB_TIMEOUT_EN : when defined, a grant held for MAX_HOLD cycles without
//                    done is revoked and timeout pulses. When undefined no
//                    hold counter exists and timeout is tied low.
// ---------------------------------------------------------------------------
module mux8_rr_arbiter
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             done,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic             sel_s0,
   output logic             sel_s1,
   output logic             sel_s2,
   output logic             timeout
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux8_rr_arbiter: MAX_HOLD must be in 2..255");
   end

   state_t           state;
   logic [N_REQ-1:0] gnt_q;
   logic             gnt_valid_q;
   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] ptr_q;

   logic [SEL_W-1:0] gidx;
   logic             withdraw;
   logic             to_hit;
   logic             rel;
   logic             arb;

   logic [N_REQ-1:0] pk_mask;
   logic             pk_found;
   logic [SEL_W-1:0] pk_idx;
   logic [N_REQ-1:0] pk_onehot;

   logic             nxt_found;
   logic [SEL_W-1:0] nxt_idx;
   logic [N_REQ-1:0] nxt_onehot;

   assign gidx     = onehot_to_idx(gnt_q);
   assign withdraw = (state == BUSY) && !req[gidx];
   assign rel      = (state == BUSY) && (done || withdraw || to_hit);
   assign arb      = (state == IDLE) || rel;

   // While busy, the releasing requester is excluded from the first search.
   assign pk_mask = (state == BUSY) ? ~gnt_q : '1;

   rr_pick8 u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .mask   (pk_mask),
      .found  (pk_found),
      .idx    (pk_idx),
      .onehot (pk_onehot)
   );

   // A still-requesting releaser is re-granted only when nobody else asks.
   always_comb begin
      nxt_found  = pk_found;
      nxt_idx    = pk_idx;
      nxt_onehot = pk_onehot;
      if ((state == BUSY) && !pk_found && req[gidx]) begin
         nxt_found  = 1'b1;
         nxt_idx    = gidx;
         nxt_onehot = gnt_q;
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
   localparam logic [CNT_W-1:0] HOLD_SAT  = '1;

   logic [CNT_W-1:0] hold_cnt;
   logic             timeout_q;

   // Forced revoke only when nothing else is already ending the grant.
   assign to_hit = (state == BUSY) && (hold_cnt == HOLD_LAST) && !done && !withdraw;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         timeout_q <= to_hit;
         if (arb) begin
            hold_cnt <= '0;
         end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
         end
      end
   end

   assign timeout = timeout_q;
`else
   assign to_hit  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         gnt_q       <= '0;
         gnt_valid_q <= 1'b0;
         sel_q       <= '0;
         ptr_q       <= '0;
      end else if (arb) begin
         if (nxt_found) begin
            state       <= BUSY;
            gnt_q       <= nxt_onehot;
            gnt_valid_q <= 1'b1;
            sel_q       <= nxt_idx;
            ptr_q       <= nxt_idx + SEL_W'(1);
         end else begin
            // sel keeps its last value while idle
            state       <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
         end
      end
   end

   assign gnt       = gnt_q;
   assign gnt_valid = gnt_valid_q;
   assign sel_s0    = sel_q[2];
   assign sel_s1    = sel_q[1];
   assign sel_s2    = sel_q[0];

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
`timescale 1ns/1ps
module tb_mux8_rr_arbiter;

   localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] gnt;
   logic       gnt_valid, sel_s0, sel_s1, sel_s2, timeout;

   int n_cmp = 0;
   int n_bad = 0;

   // expected {gnt, gnt_valid, sel[2:0], timeout}
   logic [12:0] exp_q[$];

   // reference model state
   bit m_busy;
   int m_owner, m_ptr, m_hold, m_sel;
   bit m_to;

   always #5 clk = ~clk;

   mux8_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .sel_s0    (sel_s0),
      .sel_s1    (sel_s1),
      .sel_s2    (sel_s2),
      .timeout   (timeout)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy = 0; m_owner = 0; m_ptr = 0; m_hold = 0; m_sel = 0; m_to = 0;
   endtask

   // Advance the model by one clock edge given the inputs seen at that edge.
   task automatic model_step(input logic [7:0] r, input logic d);
      bit arb, wd;
      int w, j;
      m_to = 0;
      if (!rst_n) begin
         model_reset();
         return;
      end
      if (!m_busy) arb = 1;
      else begin
         wd   = !r[m_owner];
         m_to = TO_EN && (m_hold == MAX_HOLD - 1) && !d && !wd;
         arb  = d || wd || m_to;
      end
      if (arb) begin
         w = -1;
         for (int k = 0; k < 8; k++) begin
            j = (m_ptr + k) % 8;
            if (r[j] && !(m_busy && j == m_owner)) begin
               w = j;
               break;
            end
         end
         if (w < 0 && m_busy && r[m_owner]) w = m_owner;
         m_hold = 0;
         if (w >= 0) begin
            m_busy = 1; m_owner = w; m_sel = w; m_ptr = (w + 1) % 8;
         end else begin
            m_busy = 0;
         end
      end else if (m_hold < 7) begin
         m_hold++;
      end
   endtask

   function automatic logic [12:0] model_out();
      logic [7:0] g;
      g = m_busy ? 8'(1 << m_owner) : 8'h00;
      return {g, m_busy, 3'(m_sel), m_to};
   endfunction

   // Drive one cycle from a falling edge, predict, and wait for the next falling edge.
   task automatic cyc(input logic [7:0] r, input logic d);
      req  = r;
      done = d;
      model_step(r, d);
      exp_q.push_back(model_out());
      @(negedge clk);
   endtask

   task automatic hard_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_valid", 32'(gnt_valid), 32'h0);
      chk("rst_sel", 32'({sel_s0, sel_s1, sel_s2}), 32'h0);
      chk("rst_timeout", 32'(timeout), 32'h0);
      cyc(8'h00, 1'b0);
      rst_n = 1'b1;
   endtask

   // Monitor: compare each presented cycle against the scoreboard.
   initial begin
      logic [12:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", 32'({gnt, gnt_valid, sel_s0, sel_s1, sel_s2, timeout}), 32'(e));
            chk("invariant", 32'(((gnt & (gnt - 8'd1)) == 8'd0) && (gnt_valid == |gnt)), 32'h1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] r;
      model_reset();
      @(negedge clk);
      hard_reset();

      // idle: done pulses are ignored
      for (int i = 0; i < 5; i++) begin
         cyc(8'h00, 1'(i % 2));
         chk("idle_out", 32'({gnt, gnt_valid, sel_s0, sel_s1, sel_s2}), 32'h0);
      end

      // two requesters, back-to-back grants on done
      cyc(8'h24, 1'b0);
      chk("pair_first", 32'(gnt), 32'h04);
      chk("pair_first_sel", 32'({sel_s0, sel_s1, sel_s2}), 32'h2);
      cyc(8'h24, 1'b1);
      chk("pair_second", 32'(gnt), 32'h20);
      chk("pair_second_sel", 32'({sel_s0, sel_s1, sel_s2}), 32'h5);
      cyc(8'h00, 1'b1);
      chk("pair_idle", 32'({gnt, gnt_valid}), 32'h0);

      // all requesting, done every third cycle: strict rotation
      hard_reset();
      cyc(8'hFF, 1'b0);
      for (int k = 0; k < 9; k++) begin
         chk("rotation", 32'(gnt), 32'(1 << (k % 8)));
         cyc(8'hFF, 1'b0);
         cyc(8'hFF, 1'b0);
         cyc(8'hFF, 1'b1);
      end

      // withdrawal of granted requester 3
      hard_reset();
      cyc(8'h08, 1'b0);
      chk("wd_grant", 32'(gnt), 32'h08);
      cyc(8'h81, 1'b0);
      chk("wd_next", 32'(gnt), 32'h80);
      chk("wd_sel", 32'({sel_s0, sel_s1, sel_s2}), 32'h7);

      // long hold without done
      hard_reset();
      cyc(8'h03, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("hold_gnt", 32'(gnt), 32'h01);
         cyc(8'h03, 1'b0);
      end
      chk("hold_end_gnt", 32'(gnt), TO_EN ? 32'h02 : 32'h01);
      chk("hold_end_timeout", 32'(timeout), TO_EN ? 32'h1 : 32'h0);
      cyc(8'h03, 1'b0);
      chk("timeout_pulse_width", 32'(timeout), 32'h0);

      // reset mid-grant
      hard_reset();
      cyc(8'h40, 1'b0);
      chk("mid_grant", 32'(gnt), 32'h40);
      cyc(8'h40, 1'b0);
      hard_reset();
      cyc(8'h41, 1'b0);
      chk("after_rst_grant", 32'(gnt), 32'h01);

      // randomized traffic
      r = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 99) == 0) hard_reset();
         if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 2))
               0: r = 8'($urandom) & 8'($urandom);
               1: r = 8'($urandom);
               default: r = 8'h00;
            endcase
         end
         cyc(r, 1'($urandom_range(0, 3) == 0));
      end

      cyc(8'h00, 1'b1);
      cyc(8'h00, 1'b0);
      @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
